// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register with a 2-entry skid buffer; in_ready and out_valid are decoded from state flops only.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              pop;

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_buf: DATA_W and CNT_W must be at least 1");
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every output gets a hold default first so no path through the case infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the pop side can move.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: the payload registers are reset as well, so out_data reads 0 whenever the stage is empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: they stick at all-ones until reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue model of the held entries predicts in_ready, out_valid and out_data.
// With PIPE_STAGE_PERF_EN defined it also checks the counters, including a CNT_W=2 saturating instance.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  int          stall_exp = 0;
  int          flush_exp = 0;

  always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic        in_ready_s, out_valid_s;
  logic [63:0] out_data_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  pipe_stage_buf #(.DATA_W(64), .CNT_W(32)) u_dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_buf #(.DATA_W(64), .CNT_W(2)) u_dut_sat (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );
`else
  pipe_stage_buf #(.DATA_W(64), .CNT_W(32)) u_dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sat2(input int v);
    return (v > 3) ? 64'd3 : 64'(v);
  endfunction

  task automatic check_outputs();
    logic [63:0] exp_data;
    exp_data = (sb_q.size() != 0) ? sb_q[0] : 64'd0;
    check("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
    check("in_ready",  {63'd0, in_ready},  {63'd0, sb_q.size() < 2});
    check("out_data",  out_data, exp_data);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt",     {32'd0, stall_cnt},   64'(stall_exp));
    check("flush_cnt",     {32'd0, flush_cnt},   64'(flush_exp));
    check("stall_cnt_sat", {62'd0, stall_cnt_s}, sat2(stall_exp));
    check("flush_cnt_sat", {62'd0, flush_cnt_s}, sat2(flush_exp));
    check("out_data_sat",  out_data_s, exp_data);
`endif
  endtask

  // Called just after a falling edge: drive, check pre-edge outputs, clock, update the model.
  task automatic step(input logic v, input logic [63:0] d, input logic rdy, input logic fl);
    bit acc, pp;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #1;
    check_outputs();
    acc = v && (sb_q.size() < 2);
    pp  = rdy && (sb_q.size() != 0);
    @(posedge CLK);
    if (sb_q.size() != 0 && !rdy) stall_exp++;
    if (fl) begin
      if (sb_q.size() != 0) flush_exp++;
      sb_q.delete();
    end else begin
      if (pp) void'(sb_q.pop_front());
      if (acc) sb_q.push_back(d);
    end
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;

    // Single payload after reset.
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b1, 64'hA, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);

    // Back-to-back streaming.
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);

    // Backpressure fills the skid; a third offer while FULL is ignored.
    step(1'b1, 64'd5,  1'b0, 1'b0);
    step(1'b1, 64'd6,  1'b0, 1'b0);
    step(1'b1, 64'd99, 1'b0, 1'b0);
    step(1'b0, 64'd0,  1'b0, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);

    // Flush while FULL with a same-cycle payload 7.
    step(1'b1, 64'h15, 1'b0, 1'b0);
    step(1'b1, 64'h16, 1'b0, 1'b0);
    step(1'b1, 64'd7,  1'b0, 1'b1);
    step(1'b0, 64'd0,  1'b1, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);

    // Several stalls push the CNT_W=2 counter past saturation.
    step(1'b1, 64'h40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream while FULL.
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    sb_q.delete();
    stall_exp = 0;
    flush_exp = 0;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("async_rst_out_data",  out_data,           64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b1, 64'h33, 1'b1, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);
    step(1'b0, 64'd0,  1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
